// File: rtl/cpu_register_file_mp.sv
// Integer register file for the Rv32H core.
// Decode reads registers and claims destinations, and writeback writes results.
// Each of the three request paths uses a tag-toggle handshake: a request starts
// when the incoming tag differs from the tag last serviced on that path.
// Read data written on the same edge is forwarded to the reader (bypass).
// A per-register busy scoreboard lets decode stall on producers that are still
// in flight. Register 0 always reads as zero and is never marked busy.
module cpu_register_file_mp #(
    parameter int              XLEN     = 32,
    parameter int              NREGS    = 32,
    parameter int              NREAD    = 2,
    parameter int              TAGW     = 8,
    parameter int              SP_IDX   = 2,
    parameter logic [XLEN-1:0] SP_RESET = 32'h00010400
) (
    input  logic                             i_clock,
    input  logic                             i_reset,
    // read port: every channel is serviced by one read request
    input  logic [TAGW-1:0]                  i_read_tag,
    input  logic [NREAD*$clog2(NREGS)-1:0]   i_read_idx,
    output logic [NREAD*XLEN-1:0]            o_rdata,
    output logic [NREAD-1:0]                 o_rbusy,
    output logic [TAGW-1:0]                  o_read_ack,
    // write port from writeback
    input  logic [TAGW-1:0]                  i_write_tag,
    input  logic [$clog2(NREGS)-1:0]         i_write_idx,
    input  logic [XLEN-1:0]                  i_wdata,
    output logic [TAGW-1:0]                  o_write_ack,
    // claim port from decode: marks a destination as pending
    input  logic [TAGW-1:0]                  i_claim_tag,
    input  logic [$clog2(NREGS)-1:0]         i_claim_idx,
    output logic [NREGS-1:0]                 o_busy
);

    localparam int IDXW = $clog2(NREGS);

    // Architectural state
    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] busy_q;
    logic [TAGW-1:0]  read_tag_q;
    logic [TAGW-1:0]  write_tag_q;
    logic [TAGW-1:0]  claim_tag_q;

    // Request decode
    logic read_fire;
    logic write_fire;
    logic claim_fire;
    logic write_en;
    logic claim_en;

    // Next-state values
    logic [IDXW-1:0]       ridx [NREAD];
    logic [NREGS-1:0]      busy_d;
    logic [NREAD*XLEN-1:0] rdata_d;
    logic [NREAD-1:0]      rbusy_d;

    // A request is a tag that differs from the last one serviced; wrap is just
    // another difference, and a held tag never re-fires.
    assign read_fire  = (i_read_tag  != read_tag_q);
    assign write_fire = (i_write_tag != write_tag_q);
    assign claim_fire = (i_claim_tag != claim_tag_q);

    // Index 0 requests are still acknowledged but never touch state.
    assign write_en = write_fire && (i_write_idx != '0);
    assign claim_en = claim_fire && (i_claim_idx != '0);

    assign o_busy = busy_q;

    // Split the packed read index bus into one index per channel.
    always_comb begin
        for (int k = 0; k < NREAD; k++) begin
            ridx[k] = i_read_idx[k*IDXW +: IDXW];
        end
    end

    // Scoreboard update: write clears, then claim sets, so a claim on the same
    // edge as a write to the same register wins (the newer producer is pending).
    always_comb begin
        busy_d = busy_q;
        if (write_en) begin
            busy_d[i_write_idx] = 1'b0;
        end
        if (claim_en) begin
            busy_d[i_claim_idx] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Per-channel read data with same-edge write bypass, and busy status as it
    // stands after this edge's write and claim.
    always_comb begin
        rdata_d = '0;
        rbusy_d = '0;
        for (int k = 0; k < NREAD; k++) begin
            if (ridx[k] != '0) begin
                if (write_en && (i_write_idx == ridx[k])) begin
                    rdata_d[k*XLEN +: XLEN] = i_wdata;
                end else begin
                    rdata_d[k*XLEN +: XLEN] = regs[ridx[k]];
                end
            end
            rbusy_d[k] = busy_d[ridx[k]];
        end
    end

    // Register array: SP gets its boot value, everything else clears.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            for (int n = 0; n < NREGS; n++) begin
                regs[n] <= (n == SP_IDX) ? SP_RESET : '0;
            end
        end else if (write_en) begin
            regs[i_write_idx] <= i_wdata;
        end
    end

    // Scoreboard register.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // Read port: capture data, busy and tag when a read fires; hold otherwise.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            read_tag_q <= '0;
            o_read_ack <= '0;
            o_rdata    <= '0;
            o_rbusy    <= '0;
        end else if (read_fire) begin
            read_tag_q <= i_read_tag;
            o_read_ack <= i_read_tag;
            o_rdata    <= rdata_d;
            o_rbusy    <= rbusy_d;
        end
    end

    // Write and claim handshake tags.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            write_tag_q <= '0;
            o_write_ack <= '0;
            claim_tag_q <= '0;
        end else begin
            if (write_fire) begin
                write_tag_q <= i_write_tag;
                o_write_ack <= i_write_tag;
            end
            if (claim_fire) begin
                claim_tag_q <= i_claim_tag;
            end
        end
    end

endmodule

// File: tb/tb_cpu_register_file_mp.sv
// Testbench for cpu_register_file_mp: directed scenarios followed by random
// traffic, all compared against a behavioural model of the register file.
module tb_cpu_register_file_mp;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NREAD = 2;
    localparam int TAGW  = 8;
    localparam int IDXW  = 5;
    localparam logic [XLEN-1:0] SP_VAL = 32'h00010400;

    logic                   clk;
    logic                   i_reset;
    logic [TAGW-1:0]        i_read_tag;
    logic [NREAD*IDXW-1:0]  i_read_idx;
    logic [NREAD*XLEN-1:0]  o_rdata;
    logic [NREAD-1:0]       o_rbusy;
    logic [TAGW-1:0]        o_read_ack;
    logic [TAGW-1:0]        i_write_tag;
    logic [IDXW-1:0]        i_write_idx;
    logic [XLEN-1:0]        i_wdata;
    logic [TAGW-1:0]        o_write_ack;
    logic [TAGW-1:0]        i_claim_tag;
    logic [IDXW-1:0]        i_claim_idx;
    logic [NREGS-1:0]       o_busy;

    cpu_register_file_mp #(
        .XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD), .TAGW(TAGW),
        .SP_IDX(2), .SP_RESET(SP_VAL)
    ) dut (
        .i_clock(clk), .i_reset(i_reset),
        .i_read_tag(i_read_tag), .i_read_idx(i_read_idx),
        .o_rdata(o_rdata), .o_rbusy(o_rbusy), .o_read_ack(o_read_ack),
        .i_write_tag(i_write_tag), .i_write_idx(i_write_idx),
        .i_wdata(i_wdata), .o_write_ack(o_write_ack),
        .i_claim_tag(i_claim_tag), .i_claim_idx(i_claim_idx),
        .o_busy(o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model state
    logic [XLEN-1:0]       m_r [NREGS];
    logic [NREGS-1:0]      m_busy;
    logic [TAGW-1:0]       m_rtag, m_wtag, m_ctag;
    logic [NREAD*XLEN-1:0] exp_rdata;
    logic [NREAD-1:0]      exp_rbusy;
    logic [TAGW-1:0]       exp_rack, exp_wack;

    // Bench-side request tags
    logic [TAGW-1:0] rt, wt, ct;

    int n_checks = 0;
    int n_fails  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_rdata"}, 64'(o_rdata), 64'(exp_rdata));
        chk({tag, "_rbusy"}, 64'(o_rbusy), 64'(exp_rbusy));
        chk({tag, "_rack"},  64'(o_read_ack), 64'(exp_rack));
        chk({tag, "_wack"},  64'(o_write_ack), 64'(exp_wack));
        chk({tag, "_busy"},  64'(o_busy), 64'(m_busy));
    endtask

    task automatic model_reset();
        for (int n = 0; n < NREGS; n++) m_r[n] = '0;
        m_r[2]    = SP_VAL;
        m_busy    = '0;
        m_rtag    = '0;
        m_wtag    = '0;
        m_ctag    = '0;
        exp_rdata = '0;
        exp_rbusy = '0;
        exp_rack  = '0;
        exp_wack  = '0;
    endtask

    // Apply one clock edge to the model: write, then claim, then read, which
    // naturally yields bypassed data and the final busy state for the reader.
    task automatic model_step();
        int idx;
        if (i_write_tag != m_wtag) begin
            if (i_write_idx != 0) begin
                m_r[i_write_idx]    = i_wdata;
                m_busy[i_write_idx] = 1'b0;
            end
            m_wtag   = i_write_tag;
            exp_wack = i_write_tag;
        end
        if (i_claim_tag != m_ctag) begin
            if (i_claim_idx != 0) m_busy[i_claim_idx] = 1'b1;
            m_ctag = i_claim_tag;
        end
        if (i_read_tag != m_rtag) begin
            for (int k = 0; k < NREAD; k++) begin
                idx = int'(i_read_idx[k*IDXW +: IDXW]);
                exp_rdata[k*XLEN +: XLEN] = (idx == 0) ? '0 : m_r[idx];
                exp_rbusy[k] = (idx == 0) ? 1'b0 : m_busy[idx];
            end
            m_rtag   = i_read_tag;
            exp_rack = i_read_tag;
        end
    endtask

    task automatic cycle(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic set_read(input logic [IDXW-1:0] i0, input logic [IDXW-1:0] i1);
        rt = rt + 8'd1;
        i_read_tag = rt;
        i_read_idx = {i1, i0};
    endtask

    task automatic set_write(input logic [IDXW-1:0] idx, input logic [XLEN-1:0] d);
        wt = wt + 8'd1;
        i_write_tag = wt;
        i_write_idx = idx;
        i_wdata     = d;
    endtask

    task automatic set_claim(input logic [IDXW-1:0] idx);
        ct = ct + 8'd1;
        i_claim_tag = ct;
        i_claim_idx = idx;
    endtask

    function automatic logic [IDXW-1:0] rnd_idx();
        if ($urandom_range(0, 1) == 1) return IDXW'($urandom_range(0, 7));
        return IDXW'($urandom_range(0, NREGS - 1));
    endfunction

    task automatic reset_pulse(input string tag);
        rt = '0; wt = '0; ct = '0;
        i_read_tag = '0; i_write_tag = '0; i_claim_tag = '0;
        #2 i_reset = 1'b1;
        #1;
        model_reset();
        check_all(tag);
        #1 i_reset = 1'b0;
    endtask

    initial begin
        i_reset = 1'b1;
        i_read_tag = '0; i_read_idx = '0;
        i_write_tag = '0; i_write_idx = '0; i_wdata = '0;
        i_claim_tag = '0; i_claim_idx = '0;
        rt = '0; wt = '0; ct = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        i_reset = 1'b0;
        @(posedge clk);
        #1;
        // Stir up some state, then reset mid-cycle
        set_write(5'd5, 32'h55555555); set_claim(5'd6); set_read(5'd5, 5'd6);
        cycle("pre_reset");
        reset_pulse("reset");

        // SP boot value and a zeroed register
        set_read(5'd2, 5'd5);
        cycle("rd_sp");
        chk("sp_value", 64'(o_rdata[31:0]), 64'(32'h00010400));
        chk("r5_zero",  64'(o_rdata[63:32]), 64'd0);

        // Basic write then read, one clock latency
        set_write(5'd7, 32'hDEADBEEF);
        cycle("wr7");
        set_read(5'd7, 5'd0);
        cycle("rd7");
        chk("rd7_ch0", 64'(o_rdata[31:0]), 64'(32'hDEADBEEF));
        chk("rd7_ack", 64'(o_read_ack), 64'(rt));
        set_write(5'd0, 32'h00001234);
        cycle("wr0");
        set_read(5'd0, 5'd0);
        cycle("rd0");
        chk("rd0_ch0", 64'(o_rdata[31:0]), 64'd0);

        // Same-edge write and read bypass
        set_write(5'd9, 32'h11111111);
        cycle("wr9_old");
        set_write(5'd9, 32'hA5A5A5A5); set_read(5'd4, 5'd9);
        cycle("bypass");
        chk("bypass_ch1", 64'(o_rdata[63:32]), 64'(32'hA5A5A5A5));

        // Channel independence
        set_read(5'd0, 5'd7);
        cycle("chan_ind");
        chk("chan_ch0", 64'(o_rdata[31:0]), 64'd0);
        chk("chan_ch1", 64'(o_rdata[63:32]), 64'(32'hDEADBEEF));

        // Scoreboard
        set_claim(5'd3);
        cycle("claim3");
        chk("busy3_set", 64'(o_busy[3]), 64'd1);
        set_read(5'd3, 5'd1);
        cycle("rd_busy3");
        chk("rbusy0", 64'(o_rbusy), 64'd1);
        set_write(5'd3, 32'h33333333);
        cycle("wr3");
        chk("busy3_clr", 64'(o_busy[3]), 64'd0);
        set_write(5'd3, 32'hCAFEF00D); set_claim(5'd3); set_read(5'd3, 5'd3);
        cycle("wr_claim3");
        chk("busy3_win", 64'(o_busy[3]), 64'd1);
        chk("rd3_byp",   64'(o_rdata), {32'hCAFEF00D, 32'hCAFEF00D});
        chk("rbusy_win", 64'(o_rbusy), 64'd3);

        // Tag wrap and held tag
        wt = 8'hFD;
        set_write(5'd10, 32'h000000FE); cycle("wrap_fe");
        set_write(5'd10, 32'h000000FF); cycle("wrap_ff");
        set_write(5'd10, 32'h00000100); cycle("wrap_00");
        chk("wrap_ack", 64'(o_write_ack), 64'h00);
        i_wdata = 32'hBAD0BAD0;
        for (int i = 0; i < 10; i++) cycle("hold");
        set_read(5'd10, 5'd0);
        cycle("rd_hold");
        chk("hold_single", 64'(o_rdata[31:0]), 64'h100);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) != 0) begin
                wt = wt + TAGW'($urandom_range(1, 255));
                i_write_tag = wt;
                i_write_idx = rnd_idx();
                i_wdata     = $urandom;
            end
            if ($urandom_range(0, 2) == 0) begin
                ct = ct + TAGW'($urandom_range(1, 255));
                i_claim_tag = ct;
                i_claim_idx = rnd_idx();
            end
            if ($urandom_range(0, 1) == 1) begin
                rt = rt + TAGW'($urandom_range(1, 255));
                i_read_tag = rt;
                i_read_idx = {rnd_idx(), rnd_idx()};
            end else begin
                i_read_idx = {rnd_idx(), rnd_idx()};
            end
            cycle("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
